// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock first-word-fall-through (FWFT) FIFO with valid/ready handshakes, an exact occupancy count and threshold flags.
// Optional feature macro FIFO_ERR_FLAGS_EN: adds the sticky overflow/underflow outputs.
module param_sync_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
`else
  output logic              almost_empty
`endif
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AW != $clog2(DEPTH) ||
      !(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_params
    $error("param_sync_fifo: illegal DEPTH/AW/AF_LEVEL/AE_LEVEL combination");
  end

  localparam logic [AW:0] AF_L = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_L = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] FULL_L = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push, pop, flush_en;

  assign count        = count_q;
  assign full         = count_q == FULL_L;
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= AF_L;
  assign almost_empty = count_q <= AE_L;
  assign wr_ready     = ce & ~full & rst_n;
  assign rd_valid     = ce & ~empty;
  assign rd_data      = rd_valid ? mem_q[rd_ptr_q] : '0;

  // Handshakes and next-state pointers/count; flush overrides any same-cycle transfer.
  always_comb begin
    flush_en = ce & flush;
    push     = wr_valid & wr_ready & ~flush;
    pop      = rd_valid & rd_ready & ~flush;
    wr_ptr_d = flush_en ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = flush_en ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = flush_en ? '0 :
               (push & ~pop) ? count_q + (AW+1)'(1) :
               (pop & ~push) ? count_q - (AW+1)'(1) : count_q;
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is written only on an accepted push and is never reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Sticky error flags: set on a refused write/read request, cleared by flush.
  always_comb begin
    overflow_d  = flush_en ? 1'b0 : overflow_q | (ce & wr_valid & full);
    underflow_d = flush_en ? 1'b0 : underflow_q | (ce & rd_ready & empty);
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed self-checking bench for param_sync_fifo (DEPTH=8, DATA_W=32, AF=6, AE=2).
module tb_param_sync_fifo;

  logic        clk = 1'b0;
  logic        rst_n, ce, flush, wr_valid, rd_ready;
  logic [31:0] wr_data;
  logic        wr_ready, rd_valid, full, empty, almost_full, almost_empty;
  logic [31:0] rd_data;
  logic [3:0]  count;
`ifdef FIFO_ERR_FLAGS_EN
  logic        overflow, underflow;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] ae_tab = 9'b000000111;
  logic [8:0] af_tab = 9'b111000000;

  param_sync_fifo #(.DATA_W(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full),
`ifdef FIFO_ERR_FLAGS_EN
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
`else
    .almost_empty(almost_empty)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ce = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    cyc();
    n_vec++; if ({full, empty, almost_full, almost_empty, wr_ready, rd_valid} !== 6'b010100) begin n_err++; $display("FAIL reset_flags: got %b want 010100", {full, empty, almost_full, almost_empty, wr_ready, rd_valid}); end
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    cyc();
    rst_n = 1'b1;
    #1;
    n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL release_wr_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_fill_drain_thresholds;
    n_vec++; if ({almost_full, almost_empty} !== {af_tab[0], ae_tab[0]}) begin n_err++; $display("FAIL thr[0]: got af/ae %b want %b", {almost_full, almost_empty}, {af_tab[0], ae_tab[0]}); end
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_data = 32'hA0 + i;
      cyc();
      n_vec++; if (count !== 4'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
      n_vec++; if ({almost_full, almost_empty} !== {af_tab[i+1], ae_tab[i+1]}) begin n_err++; $display("FAIL thr[%0d]: got af/ae %b want %b", i + 1, {almost_full, almost_empty}, {af_tab[i+1], ae_tab[i+1]}); end
    end
    wr_valid = 1'b0;
    n_vec++; if ({full, wr_ready, empty} !== 3'b100) begin n_err++; $display("FAIL full_flags: got full/wr_ready/empty %b want 100", {full, wr_ready, empty}); end
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (rd_data !== 32'hA0 + i) begin n_err++; $display("FAIL drain_data[%0d]: got %h want %h", i, rd_data, 32'hA0 + i); end
      cyc();
    end
    rd_ready = 1'b0;
    n_vec++; if ({empty, rd_valid, full} !== 3'b100) begin n_err++; $display("FAIL drain_flags: got empty/rd_valid/full %b want 100", {empty, rd_valid, full}); end
    n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL drain_rd_data: got %h want 0", rd_data); end
  endtask

  task automatic test_wrap_and_simultaneous;
    for (int i = 0; i < 5; i++) begin wr_valid = 1'b1; wr_data = 32'hB0 + i; cyc(); end
    wr_valid = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (rd_data !== 32'hB0 + i) begin n_err++; $display("FAIL wrap_pop1[%0d]: got %h want %h", i, rd_data, 32'hB0 + i); end
      cyc();
    end
    rd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin wr_valid = 1'b1; wr_data = 32'hC0 + i; cyc(); end
    wr_valid = 1'b0;
    n_vec++; if (count !== 4'd6) begin n_err++; $display("FAIL wrap_count: got %0d want 6", count); end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (rd_data !== 32'hC0 + i) begin n_err++; $display("FAIL wrap_pop2[%0d]: got %h want %h", i, rd_data, 32'hC0 + i); end
      cyc();
    end
    wr_valid = 1'b1; wr_data = 32'hD0;
    n_vec++; if (rd_data !== 32'hC3) begin n_err++; $display("FAIL simul_head_before: got %h want c3", rd_data); end
    cyc();
    wr_valid = 1'b0;
    n_vec++; if (count !== 4'd3) begin n_err++; $display("FAIL simul_count: got %0d want 3", count); end
    n_vec++; if (rd_data !== 32'hC4) begin n_err++; $display("FAIL simul_head_after: got %h want c4", rd_data); end
    cyc(); cyc();
    n_vec++; if (rd_data !== 32'hD0) begin n_err++; $display("FAIL simul_tail: got %h want d0", rd_data); end
    cyc();
    rd_ready = 1'b0;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL simul_empty: got %b want 1", empty); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 0; i < 8; i++) begin wr_valid = 1'b1; wr_data = 32'hE0 + i; cyc(); end
    wr_data = 32'hEE; rd_ready = 1'b1;
    cyc();
    wr_valid = 1'b0;
    n_vec++; if (count !== 4'd7) begin n_err++; $display("FAIL fullpp_count: got %0d want 7", count); end
    for (int i = 1; i < 8; i++) begin
      n_vec++; if (rd_data !== 32'hE0 + i) begin n_err++; $display("FAIL fullpp_data[%0d]: got %h want %h", i, rd_data, 32'hE0 + i); end
      cyc();
    end
    rd_ready = 1'b0;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL fullpp_empty: got %b want 1", empty); end
  endtask

  task automatic test_flush_ce;
    for (int i = 0; i < 4; i++) begin wr_valid = 1'b1; wr_data = 32'hF0 + i; cyc(); end
    flush = 1'b1; wr_data = 32'hFF;
    cyc();
    flush = 1'b0; wr_valid = 1'b0;
    n_vec++; if ({count, empty} !== {4'd0, 1'b1}) begin n_err++; $display("FAIL flush_count: got count %0d empty %b want 0 1", count, empty); end
    wr_valid = 1'b1; wr_data = 32'h11;
    cyc();
    ce = 1'b0; wr_data = 32'h22; rd_ready = 1'b1;
    #1;
    n_vec++; if ({wr_ready, rd_valid, almost_empty} !== 3'b001) begin n_err++; $display("FAIL ce_flags: got wr_ready/rd_valid/ae %b want 001", {wr_ready, rd_valid, almost_empty}); end
    n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL ce_rd_data: got %h want 0", rd_data); end
    cyc();
    flush = 1'b1;
    cyc();
    n_vec++; if (count !== 4'd1) begin n_err++; $display("FAIL ce_count: got %0d want 1", count); end
    ce = 1'b1; flush = 1'b0; wr_valid = 1'b0;
    #1;
    n_vec++; if (rd_data !== 32'h11) begin n_err++; $display("FAIL ce_resume_data: got %h want 11", rd_data); end
    cyc();
    rd_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) begin wr_valid = 1'b1; wr_data = 32'h60 + i; cyc(); end
    wr_valid = 1'b0;
    n_vec++; if (count !== 4'd5) begin n_err++; $display("FAIL arst_pre_count: got %0d want 5", count); end
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({count, empty, rd_data} !== {4'd0, 1'b1, 32'd0}) begin n_err++; $display("FAIL arst_now: got count %0d empty %b rd_data %h want 0 1 0", count, empty, rd_data); end
    wr_valid = 1'b1; wr_data = 32'h77;
    cyc();
    n_vec++; if ({count, wr_ready} !== {4'd0, 1'b0}) begin n_err++; $display("FAIL arst_hold: got count %0d wr_ready %b want 0 0", count, wr_ready); end
    rst_n = 1'b1; wr_data = 32'h88;
    cyc();
    wr_valid = 1'b0;
    n_vec++; if ({count, rd_data} !== {4'd1, 32'h88}) begin n_err++; $display("FAIL arst_first_push: got count %0d rd_data %h want 1 88", count, rd_data); end
    rd_ready = 1'b1;
    cyc();
    rd_ready = 1'b0;
  endtask

  task automatic test_err_flags;
`ifdef FIFO_ERR_FLAGS_EN
    for (int i = 0; i < 8; i++) begin wr_valid = 1'b1; wr_data = 32'h30 + i; cyc(); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    cyc();
    wr_valid = 1'b0;
    cyc();
    n_vec++; if ({overflow, count} !== {1'b1, 4'd8}) begin n_err++; $display("FAIL ovf_sticky: got ovf %b count %0d want 1 8", overflow, count); end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_flush: got %b want 0", overflow); end
    rd_ready = 1'b1;
    cyc();
    rd_ready = 1'b0;
    n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_set: got %b want 1", underflow); end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL udf_flush: got %b want 0", underflow); end
`endif
  endtask

  initial begin
    test_reset();
    test_fill_drain_thresholds();
    test_wrap_and_simultaneous();
    test_full_push_pop();
    test_flush_ce();
    test_async_reset();
    test_err_flags();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Parametrised single-clock FIFO for the wishbone_nn datapath, buffering words between the Wishbone slave and the NN compute core.
- Generalises the fixed 8x32 input buffer to configurable width and depth.
- Adds valid/ready handshakes, an exact occupancy count, programmable almost-full/almost-empty flags, and a synchronous flush.
- Read port is first-word-fall-through (FWFT).

Parameters:
DATA_W, 32, word width in bits
DEPTH, 8, number of entries; power of two, >= 2
AW, $clog2(DEPTH), pointer width (derived; do not override)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
ce  in  1  block enable; when low the FIFO is frozen
flush  in  1  synchronous clear of contents
wr_valid  in  1  write request
wr_ready  out  1  FIFO can accept a word
wr_data  in  DATA_W  write data
rd_valid  out  1  rd_data holds the head word
rd_ready  in  1  consumer takes the head word
rd_data  out  DATA_W  head word; 0 when rd_valid low
count  out  AW+1  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Outputs full=0, empty=1, almost_empty=1, almost_full=0, rd_valid=0, rd_data=0, wr_ready=0 while reset is asserted. Storage array is not reset.
- wr_ready = ce & !full & rst_n. rd_valid = ce & !empty. All flags are derived combinationally from registered count.
- Push: occurs when wr_valid & wr_ready at a rising edge. mem[wr_ptr] <= wr_data, wr_ptr increments.
- Pop: occurs when rd_valid & rd_ready at a rising edge. rd_ptr increments.
- FWFT: rd_data = mem[rd_ptr] combinationally when rd_valid, else 0. A word written at edge N is visible at rd_data after edge N. Zero-latency bypass of wr_data is not provided.
- Pointers are AW bits and wrap naturally DEPTH-1 -> 0. count is tracked as a separate register (AW+1 bits): +1 on push only, -1 on pop only, unchanged on push+pop.
- Simultaneous push and pop are allowed whenever both handshakes complete. When full, wr_ready=0 regardless of rd_ready, so no push occurs that cycle. When empty, rd_valid=0, so no pop occurs.
- Writes when full and reads when empty are ignored; no state changes.
- flush (with ce=1): at the next edge wr_ptr=rd_ptr=count=0. flush has priority over a same-cycle push or pop.
- ce low: no push, pop or flush. All registers hold. rd_valid=0 and wr_ready=0. Flags still reflect count.
- Reset asserted mid-transfer aborts immediately. The FIFO is empty after release, and the first edge after release behaves normally.
- Parameter legality: AE_LEVEL < AF_LEVEL <= DEPTH; elaboration fails otherwise.

Optional Feature:
FIFO_ERR_FLAGS_EN
- Defined: adds outputs overflow and underflow, each 1 bit, sticky.
  - overflow sets on an edge with ce & wr_valid & full.
  - underflow sets on an edge with ce & rd_ready & empty.
  - Both clear on rst_n low or flush.
- Not defined: these ports and their logic are absent. Illegal requests are silently ignored as above.

Test Plan:
- Reset/fill/drain, DEPTH=8, DATA_W=32: push 0xA0..0xA7 -> full=1 and count=8 after the 8th edge, wr_ready=0. Pop 8 -> data returns in order 0xA0..0xA7, then empty=1 and rd_data=0.
- Wrap-around: push 5, pop 5, push 6 -> count=6 and data in order. Confirms wr_ptr wraps 7->0 without corruption.
- Simultaneous push+pop at count=3 -> count stays 3 and the head advances. At full with rd_ready=1 and wr_valid=1 -> only the pop occurs, count=7.
- Thresholds with AF_LEVEL=6, AE_LEVEL=2: almost_empty=1 at count 0..2, 0 at 3; almost_full=0 at count 5, 1 at 6.
- Flush and ce: at count=4 assert flush with push -> count=0 next cycle, no write. With ce=0 and wr_valid=1 -> count unchanged, wr_ready=0.
- Async reset mid-stream at count=5 (rst_n low between edges) -> empty=1, count=0, rd_data=0 immediately. With FIFO_ERR_FLAGS_EN, a push at full sets overflow=1 and it persists until flush.
